// File: rtl/isq2exu_skid_buffer_pkg.sv
// ============================================================================
// Module      : isq2exu_skid_buffer_pkg
// Description : Backend-shared ROB id field constants and the wrap-bit age compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isq2exu_skid_buffer_pkg;

    localparam int ROB_SIZE_LOG = 6;
    localparam int ROBID_HI     = 247;
    localparam int ROBID_LO     = 241;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } buf_state_e;

    // True when robid is strictly younger than flush_robid; equal ids are kept.
    function automatic logic rob_older_younger(
        input logic [ROB_SIZE_LOG:0] flush_robid,
        input logic [ROB_SIZE_LOG:0] robid
    );
        return flush_robid[ROB_SIZE_LOG] ^ robid[ROB_SIZE_LOG]
             ^ (flush_robid[ROB_SIZE_LOG-1:0] < robid[ROB_SIZE_LOG-1:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/isq2exu_skid_buffer.sv
// ============================================================================
// Module      : isq2exu_skid_buffer
// Description : Two-entry registered skid buffer from issue queue to integer EXU,
//               with in-order delivery and flush squash of younger uops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isq2exu_skid_buffer
    import isq2exu_skid_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 248,
    parameter int ROBID_WIDTH = 7,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [3:0]             in_selfid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [3:0]             out_selfid,
    input  logic                   flush_valid,
    input  logic [ROBID_WIDTH-1:0] flush_robid,
    output logic [CNT_WIDTH-1:0]   stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [3:0]            head_sid_q, head_sid_d;
    logic [3:0]            skid_sid_q, skid_sid_d;
    logic [CNT_WIDTH-1:0]  stall_q;

    logic head_v, skid_v;
    logic kill_head, kill_skid;
    logic enq, deq;

    assign head_v = state_q[1];
    assign skid_v = state_q[0];

    assign kill_head = flush_valid && rob_older_younger(flush_robid, head_data_q[ROBID_HI:ROBID_LO]);
    assign kill_skid = flush_valid && rob_older_younger(flush_robid, skid_data_q[ROBID_HI:ROBID_LO]);

    assign in_ready   = !skid_v && !flush_valid;
    assign out_valid  = head_v && !kill_head;
    assign out_data   = head_data_q;
    assign out_selfid = head_sid_q;
    assign stall_cnt  = stall_q;

    assign enq = in_valid && in_ready;
    assign deq = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_sid_d  = head_sid_q;
        skid_data_d = skid_data_q;
        skid_sid_d  = skid_sid_q;

        if (flush_valid) begin
            // The skid is always younger than the head, so a killed head empties the buffer.
            if (kill_head || !head_v) begin
                state_d = ST_EMPTY;
            end else if (deq) begin
                if (skid_v && !kill_skid) begin
                    state_d     = ST_ONE;
                    head_data_d = skid_data_q;
                    head_sid_d  = skid_sid_q;
                end else begin
                    state_d = ST_EMPTY;
                end
            end else if (skid_v && kill_skid) begin
                state_d = ST_ONE;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (enq) begin
                        state_d     = ST_ONE;
                        head_data_d = in_data;
                        head_sid_d  = in_selfid;
                    end
                end
                ST_ONE: begin
                    if (enq && !deq) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                        skid_sid_d  = in_selfid;
                    end else if (enq && deq) begin
                        head_data_d = in_data;
                        head_sid_d  = in_selfid;
                    end else if (deq) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deq) begin
                        state_d     = ST_ONE;
                        head_data_d = skid_data_q;
                        head_sid_d  = skid_sid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_ONE;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clock) begin
        head_data_q <= head_data_d;
        head_sid_q  <= head_sid_d;
        skid_data_q <= skid_data_d;
        skid_sid_q  <= skid_sid_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(skid_v && !head_v));
            assert (!(head_v && skid_v && kill_head && !kill_skid));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_isq2exu_skid_buffer.sv
// ============================================================================
// Module      : tb_isq2exu_skid_buffer
// Description : Directed and randomized checks of the skid buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isq2exu_skid_buffer;

    localparam int DW = 248;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [3:0]    in_selfid;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_selfid;
    logic          flush_valid;
    logic [6:0]    flush_robid;
    logic [31:0]   stall_cnt;

    always #5 clock = ~clock;

    isq2exu_skid_buffer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_selfid   (in_selfid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_selfid  (out_selfid),
        .flush_valid (flush_valid),
        .flush_robid (flush_robid),
        .stall_cnt   (stall_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    sid;
    } uop_t;

    uop_t        q[$];
    logic [31:0] m_stall;
    logic [6:0]  next_rob;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;

    // Modular distance: younger means 1..64 steps ahead of the flush point.
    function automatic bit younger_m(input logic [6:0] f, input logic [6:0] e);
        logic [6:0] d;
        d = e - f;
        return (d >= 7'd1) && (d <= 7'd64);
    endfunction

    function automatic logic [DW-1:0] mk(input logic [6:0] rob);
        logic [255:0]  tmp;
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) tmp[i*32 +: 32] = $urandom();
        d = tmp[DW-1:0];
        d[247:241] = rob;
        return d;
    endfunction

    function automatic logic [6:0] rob_of(input logic [DW-1:0] d);
        return d[247:241];
    endfunction

    function automatic bit exp_ov();
        if (q.size() == 0) return 1'b0;
        return !(flush_valid && younger_m(flush_robid, rob_of(q[0].data)));
    endfunction

    function automatic bit exp_ir();
        return (q.size() < 2) && !flush_valid;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [DW-1:0] d,
                         input logic [3:0] sid, input logic ordy, input logic fv,
                         input logic [6:0] fr);
        reset       = rst;
        in_valid    = iv;
        in_data     = d;
        in_selfid   = sid;
        out_ready   = ordy;
        flush_valid = fv;
        flush_robid = fr;
    endtask

    task automatic sample();
        bit ov;
        @(negedge clock);
        ov = exp_ov();
        chk("in_ready", {255'd0, in_ready}, {255'd0, exp_ir()});
        chk("out_valid", {255'd0, out_valid}, {255'd0, ov});
        chk("stall_cnt", {224'd0, stall_cnt}, {224'd0, m_stall});
        if (ov) begin
            chk("out_data", {8'd0, out_data}, {8'd0, q[0].data});
            chk("out_selfid", {252'd0, out_selfid}, {252'd0, q[0].sid});
        end
    endtask

    task automatic tick();
        bit ov, ir;
        ov = exp_ov();
        ir = exp_ir();
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_stall = 32'd0;
        end else begin
            if (ov && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            if (ov && out_ready) void'(q.pop_front());
            if (flush_valid) begin
                for (int i = q.size() - 1; i >= 0; i--)
                    if (younger_m(flush_robid, rob_of(q[i].data))) q.delete(i);
            end else if (in_valid && ir) begin
                q.push_back('{data: in_data, sid: in_selfid});
                n_acc++;
                next_rob = next_rob + 7'd1;
            end
        end
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [6:0] rob, input logic ordy,
                       input logic fv, input logic [6:0] fr);
        drive(1'b0, iv, mk(rob), 4'($urandom()), ordy, fv, fr);
        sample();
        tick();
    endtask

    initial begin
        m_stall  = 32'd0;
        next_rob = 7'h60;

        drive(1'b1, 1'b0, '0, 4'd0, 1'b0, 1'b0, 7'd0);
        tick();
        tick();

        // Single uop passes through with one-cycle latency.
        drive(1'b0, 1'b1, mk(7'h05), 4'd3, 1'b1, 1'b0, 7'd0);
        sample();
        chk("t1_ir_pre", {255'd0, in_ready}, 256'd1);
        tick();
        drive(1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b0, 7'd0);
        sample();
        chk("t1_ov", {255'd0, out_valid}, 256'd1);
        chk("t1_rob", {249'd0, out_data[247:241]}, 256'h05);
        chk("t1_ir", {255'd0, in_ready}, 256'd1);
        tick();

        // Fill to FULL while stalled, then drain in order.
        cyc(1'b1, 7'h10, 1'b0, 1'b0, 7'd0);
        cyc(1'b1, 7'h11, 1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b0, 7'd0);
        sample();
        chk("t2_ir_full", {255'd0, in_ready}, 256'd0);
        chk("t2_stall1", {224'd0, stall_cnt}, 256'd1);
        tick();
        drive(1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b0, 7'd0);
        sample();
        chk("t2_stall2", {224'd0, stall_cnt}, 256'd2);
        chk("t2_rob10", {249'd0, out_data[247:241]}, 256'h10);
        tick();
        sample();
        chk("t2_rob11", {249'd0, out_data[247:241]}, 256'h11);
        tick();
        cyc(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);

        // Flush at the head id keeps the head and kills the skid.
        cyc(1'b1, 7'h10, 1'b0, 1'b0, 7'd0);
        cyc(1'b1, 7'h11, 1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b1, 7'h10);
        sample();
        chk("t3_ov", {255'd0, out_valid}, 256'd1);
        chk("t3_rob", {249'd0, out_data[247:241]}, 256'h10);
        tick();
        drive(1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b0, 7'd0);
        sample();
        chk("t3_ir_one", {255'd0, in_ready}, 256'd1);
        tick();
        cyc(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);
        cyc(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);

        // Wrap-bit age compare across the 0x3F/0x40 boundary.
        cyc(1'b1, 7'h3E, 1'b0, 1'b0, 7'd0);
        cyc(1'b1, 7'h40, 1'b0, 1'b0, 7'd0);
        cyc(1'b0, 7'd0, 1'b0, 1'b1, 7'h3F);
        drive(1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b0, 7'd0);
        sample();
        chk("t4_rob", {249'd0, out_data[247:241]}, 256'h3E);
        chk("t4_ir", {255'd0, in_ready}, 256'd1);
        tick();
        cyc(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);

        // Killed head cannot fire even with out_ready high.
        cyc(1'b1, 7'h50, 1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b1, 7'h4F);
        sample();
        chk("t5_ov_kill", {255'd0, out_valid}, 256'd0);
        tick();
        drive(1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b0, 7'd0);
        sample();
        chk("t5_empty", {255'd0, out_valid}, 256'd0);
        tick();

        // Randomized stream with occasional flushes and one mid-stream reset.
        begin
            int  cycles;
            bit  did_rst;
            logic [6:0] fr;
            cycles  = 0;
            did_rst = 1'b0;
            n_acc   = 0;
            while (n_acc < 100 && cycles < 3000) begin
                cycles++;
                if (!did_rst && n_acc >= 50) begin
                    did_rst = 1'b1;
                    drive(1'b1, 1'b1, mk(next_rob), 4'd1, 1'($urandom()), 1'($urandom()), next_rob);
                    sample();
                    tick();
                    drive(1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b0, 7'd0);
                    sample();
                    chk("rst_stall", {224'd0, stall_cnt}, 256'd0);
                    chk("rst_ov", {255'd0, out_valid}, 256'd0);
                    chk("rst_ir", {255'd0, in_ready}, 256'd1);
                    tick();
                end else begin
                    if (q.size() > 0) fr = rob_of(q[0].data) + 7'($urandom_range(0, 3)) - 7'd1;
                    else              fr = next_rob - 7'd1;
                    cyc(($urandom() % 4) != 0, next_rob, 1'($urandom()),
                        ($urandom() % 8) == 0, fr);
                end
            end
            chk("stream_done", 256'(n_acc), 256'd100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
